// File: rtl/ksa8_arbiter_if.sv
// ---------------------------------------------------------------------------
// ksa8_arbiter_if
// Bus bundle between the requesters, the round-robin arbiter and the shared
// pipelined 8-bit Kogge-Stone adder.
//   req_*  : per-requester valid/ready handshake with operand bytes, carry-in
//            and last-beat flag (requester i owns byte lane [8i+7:8i])
//   add_*  : issue strobe and operands towards the adder, sum/carry back
//   rsp_*  : tagged result stream back to the requesters (no backpressure)
// modport slave  : the arbiter
// modport master : the environment (requesters plus adder)
// ---------------------------------------------------------------------------
interface ksa8_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;

  logic              add_valid;
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic              add_cin;
  logic [7:0]        add_sum;
  logic              add_cout;

  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_sum;
  logic              rsp_cout;
  logic              rsp_last;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_last, add_sum, add_cout,
    output req_ready, add_valid, add_a, add_b, add_cin,
           rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_last, add_sum, add_cout,
    input  req_ready, add_valid, add_a, add_b, add_cin,
           rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
  );
endinterface

// File: rtl/ksa8_arbiter.sv
// ---------------------------------------------------------------------------
// ksa8_arbiter
// Round-robin scheduler sharing one pipelined 8-bit Kogge-Stone adder between
// NREQ requesters. Single-byte operations from any requester issue one per
// cycle; multi-byte chained operations lock the adder to one owner and keep
// a single beat in flight so that each beat's carry-out feeds the next beat.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ksa8_arbiter_if.slave (req_*, add_*, rsp_* groups)
// Parameters: NREQ requesters, LAT adder latency in cycles, IDW = clog2(NREQ)
// ---------------------------------------------------------------------------
module ksa8_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  ksa8_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ARB         = 2'd0,
    CHAIN_WAIT  = 2'd1,
    CHAIN_ISSUE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IDW-1:0]   ptr_r, ptr_s;
  logic [IDW-1:0]   owner_r, owner_s;
  logic             carry_r, carry_s;

  logic [IDW-1:0]   winner_s;
  logic             win_found_s;
  logic [NREQ-1:0]  grant_s;
  logic [IDW-1:0]   sel_s;
  logic             cin_s;
  logic             fire_s;
  logic             ret_s;
  logic [7:0]       sel_a_s;
  logic [7:0]       sel_b_s;
  logic             sel_last_s;

  logic             add_valid_r;
  logic [7:0]       add_a_r;
  logic [7:0]       add_b_r;
  logic             add_cin_r;

  // Tag pipe: stage k describes the beat issued to the adder k+1 cycles ago;
  // stage LAT lines up with add_sum/add_cout.
  logic             tag_v_r    [0:LAT];
  logic [IDW-1:0]   tag_id_r   [0:LAT];
  logic             tag_last_r [0:LAT];

  logic             rsp_valid_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [7:0]       rsp_sum_r;
  logic             rsp_cout_r;
  logic             rsp_last_r;

  // Next requester index after v, wrapping at NREQ.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    logic [IDW-1:0] r;
    if (v == IDW'(NREQ - 1)) begin
      r = {IDW{1'b0}};
    end else begin
      r = v + IDW'(1);
    end
    return r;
  endfunction

  // Round-robin scan: first valid requester at or after ptr.
  always_comb begin
    logic [IDW:0] cand_v;
    win_found_s = 1'b0;
    winner_s    = {IDW{1'b0}};
    cand_v      = {(IDW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_v = {1'b0, ptr_r} + (IDW+1)'(k);
      if (cand_v >= (IDW+1)'(NREQ)) begin
        cand_v = cand_v - (IDW+1)'(NREQ);
      end else begin
        cand_v = cand_v;
      end
      if (!win_found_s && bus.req_valid[cand_v[IDW-1:0]]) begin
        win_found_s = 1'b1;
        winner_s    = cand_v[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // The owner's chain beat is back from the adder. Only non-last beats can
  // match: any earlier single beat or closing chain beat of the same
  // requester carries last=1.
  assign ret_s = tag_v_r[LAT] && (tag_id_r[LAT] == owner_r) && !tag_last_r[LAT];

  // FSM next state, grant and selected-beat mux.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    carry_s = carry_r;
    grant_s = {NREQ{1'b0}};
    sel_s   = winner_s;
    cin_s   = carry_r;
    case (state_r)
      ARB: begin
        sel_s = winner_s;
        cin_s = bus.req_cin[winner_s];
        if (win_found_s) begin
          grant_s[winner_s] = 1'b1;
          if (bus.req_last[winner_s]) begin
            ptr_s = wrap_inc(winner_s);
          end else begin
            state_s = CHAIN_WAIT;
            owner_s = winner_s;
          end
        end else begin
          state_s = ARB;
        end
      end
      CHAIN_WAIT: begin
        if (ret_s) begin
          state_s = CHAIN_ISSUE;
          carry_s = bus.add_cout;
        end else begin
          state_s = CHAIN_WAIT;
        end
      end
      CHAIN_ISSUE: begin
        sel_s = owner_r;
        cin_s = carry_r;
        if (bus.req_valid[owner_r]) begin
          grant_s[owner_r] = 1'b1;
          if (bus.req_last[owner_r]) begin
            state_s = ARB;
            ptr_s   = wrap_inc(owner_r);
          end else begin
            state_s = CHAIN_WAIT;
          end
        end else begin
          state_s = CHAIN_ISSUE;
        end
      end
      default: begin
        state_s = ARB;
      end
    endcase
  end

  assign fire_s     = |grant_s;
  assign sel_a_s    = bus.req_a[{sel_s, 3'b000} +: 8];
  assign sel_b_s    = bus.req_b[{sel_s, 3'b000} +: 8];
  assign sel_last_s = bus.req_last[sel_s];

  // Ready must read 0 for the whole time reset is asserted.
  assign bus.req_ready = rst ? {NREQ{1'b0}} : grant_s;

  // FSM state register with pointer, owner and captured chain carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARB;
      ptr_r   <= {IDW{1'b0}};
      owner_r <= {IDW{1'b0}};
      carry_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      carry_r <= carry_s;
    end
  end

  // Adder issue registers; operands hold their value between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_valid_r <= 1'b0;
      add_a_r     <= 8'h00;
      add_b_r     <= 8'h00;
      add_cin_r   <= 1'b0;
    end else if (fire_s) begin
      add_valid_r <= 1'b1;
      add_a_r     <= sel_a_s;
      add_b_r     <= sel_b_s;
      add_cin_r   <= cin_s;
    end else begin
      add_valid_r <= 1'b0;
    end
  end

  // Tag pipe: loads the issuing beat and shifts every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LAT; k++) begin
        tag_v_r[k]    <= 1'b0;
        tag_id_r[k]   <= {IDW{1'b0}};
        tag_last_r[k] <= 1'b0;
      end
    end else begin
      tag_v_r[0]    <= fire_s;
      tag_id_r[0]   <= sel_s;
      tag_last_r[0] <= sel_last_s;
      for (int k = 1; k <= LAT; k++) begin
        tag_v_r[k]    <= tag_v_r[k-1];
        tag_id_r[k]   <= tag_id_r[k-1];
        tag_last_r[k] <= tag_last_r[k-1];
      end
    end
  end

  // Response register: adder result passed through with its tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {IDW{1'b0}};
      rsp_sum_r   <= 8'h00;
      rsp_cout_r  <= 1'b0;
      rsp_last_r  <= 1'b0;
    end else begin
      rsp_valid_r <= tag_v_r[LAT];
      rsp_id_r    <= tag_id_r[LAT];
      rsp_sum_r   <= bus.add_sum;
      rsp_cout_r  <= bus.add_cout;
      rsp_last_r  <= tag_last_r[LAT];
    end
  end

  assign bus.add_valid = add_valid_r;
  assign bus.add_a     = add_a_r;
  assign bus.add_b     = add_b_r;
  assign bus.add_cin   = add_cin_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.rsp_cout  = rsp_cout_r;
  assign bus.rsp_last  = rsp_last_r;

endmodule

// File: doc/ksa8_arbiter.md
# ksa8_arbiter

Round-robin scheduler that shares one pipelined 8-bit Kogge-Stone adder (KSA8) between NREQ requesters. It supports single-byte additions and multi-byte chained additions, where the carry from one byte feeds the next. It sits between requesting datapath blocks and the KSA8 instance. It registers the operands into the adder, tracks in-flight operations in a LAT-deep tag pipe, and returns tagged results.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- LAT, 4: adder latency in clk cycles, from add_valid to add_sum/add_cout valid (≥1).
- IDW, 2: requester-ID width, clog2(NREQ).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  8*NREQ  operand A bytes; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  operand B bytes.
- req_cin  in  NREQ  carry-in; used on the first beat only.
- req_last  in  NREQ  1 = final (or only) beat of the operation.
- add_valid  out  1  adder issue strobe.
- add_a  out  8  operand A to the adder (drives its a0..a7).
- add_b  out  8  operand B to the adder (drives its b0..b7).
- add_cin  out  1  carry-in to the adder.
- add_sum  in  8  adder sum (from sum0..sum7).
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  result valid, one cycle per beat; no backpressure.
- rsp_id  out  IDW  requester that issued the beat.
- rsp_sum  out  8  sum byte.
- rsp_cout  out  1  carry-out of the beat.
- rsp_last  out  1  final beat of the operation.

## Operation

- Handshake: a beat transfers on the edge where req_valid[i] and req_ready[i] are both 1. The requester holds a, b, cin and last stable while valid is high and ready is low.
- States:
  - ARB: req_ready goes to the round-robin winner, which is the first valid requester at or after ptr. Grant is combinational.
  - CHAIN_WAIT: all req_ready are 0.
  - CHAIN_ISSUE: req_ready goes only to owner, when its req_valid is high.
- Transitions:
  - ARB → ARB on a last beat or when idle. On a last beat, ptr ← winner+1 mod NREQ.
  - ARB → CHAIN_WAIT on a non-last beat. owner ← winner.
  - CHAIN_WAIT → CHAIN_ISSUE on the edge where the owner's in-flight beat returns. carry ← add_cout.
  - CHAIN_ISSUE → CHAIN_WAIT on a non-last beat.
  - CHAIN_ISSUE → ARB on a last beat. ptr ← owner+1.
- Carry: on the first beat, add_cin = req_cin. On later beats, add_cin = the captured carry and req_cin is ignored.
- Pipelining: single-beat operations from any requesters issue back-to-back, one per cycle. A chain keeps only one beat in flight at a time.
- Tag pipe: LAT+1 stages carrying {valid, id, last}, shifted every cycle. Results are always captured, since there is no stall path.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, modulo 2^9. The block passes the adder output straight through and does not recompute it.

## Timing

- Handshake in cycle t:
  - add_valid, add_a, add_b and add_cin are registered and high/valid during cycle t+1.
  - add_sum and add_cout are sampled during cycle t+1+LAT.
  - rsp_* are registered and valid during cycle t+2+LAT.
  - Latency is LAT+2 cycles.
- add_valid is high for exactly one cycle per beat. add_a, add_b and add_cin hold their last values when add_valid is 0.
- Chain throughput: the next beat can be accepted in cycle t+2+LAT at the earliest, so one beat per LAT+2 cycles.
- Simultaneous events: a chain return and an issue in the same cycle are legal. The tag pipe shifts and loads on the same edge.
- Reset, asserted in any cycle, immediately forces:
  - all outputs to 0: req_ready, add_valid, add_a, add_b, add_cin and all rsp_*;
  - state = ARB, ptr = 0, carry = 0, owner = 0;
  - the tag pipe cleared.
- Adder results still in flight at reset are discarded and produce no rsp_valid.

## Test plan

- Single beat: req0 sends a=0xFF, b=0x01, cin=0, last=1. Expect rsp_valid at LAT+2 cycles with id=0, sum=0x00, cout=1, last=1.
- Back-to-back: req0..3 all valid with single beats from reset (ptr=0). Expect grants 0,1,2,3 on consecutive cycles, then four rsp on consecutive cycles with ids 0,1,2,3.
- Chain: req2 sends 0x01FF + 0x0001 as two beats, low byte first, cin=1 on the first beat.
  - Beat 1 result: sum=0x01, cout=1.
  - Beat 2 result: sum=0x02, cout=0 (its add_cin must be 1).
  - req0 and req1 stay not-ready until beat 2 is accepted, and the gap between accepts is LAT+2 cycles.
- Fairness: req0 and req1 both hold valid with continuous single beats. Grants alternate 0,1,0,1.
- Reset mid-operation: assert rst two cycles after a chain's first beat. Expect no rsp_valid and all outputs 0. After release, a fresh single beat from req3 is granted (ptr=0 scan) and returns the correct result.
